pipe_stage_regs: RTL and testbench

//  Fetch-to-execute pipeline registers of the 5-stage MIPS core: PC register, IF/ID and ID/EX.

---
 rtl/pipe_stage_regs_if.sv | 53 +++++
 rtl/pipe_stage_regs.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_regs.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_regs_if.sv
// Fetch/decode/execute pipeline register bus.
// master drives the F/D-side inputs and hazard controls; slave is the register block.
interface pipe_stage_regs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 8
);
  // fetch-side inputs
  logic [DATA_W-1:0] PCNextF;
  logic [DATA_W-1:0] InstrF;
  // hazard unit controls
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  // decode-side inputs
  logic [CTRL_W-1:0] CtrlD;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [REG_W-1:0]  RsD;
  logic [REG_W-1:0]  RtD;
  logic [REG_W-1:0]  RdD;
  logic [DATA_W-1:0] SignImmD;
  // registered outputs
  logic [DATA_W-1:0] PCF;
  logic [DATA_W-1:0] InstrD;
  logic [DATA_W-1:0] PCPlus4D;
  logic              ValidD;
  logic [CTRL_W-1:0] CtrlE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [REG_W-1:0]  RsE;
  logic [REG_W-1:0]  RtE;
  logic [REG_W-1:0]  RdE;
  logic [DATA_W-1:0] SignImmE;
  logic              ValidE;
  logic [31:0]       StallCnt;
  logic [31:0]       FlushCnt;

  modport master (
    output PCNextF, InstrF, StallF, StallD, FlushD, FlushE,
           CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    input  PCF, InstrD, PCPlus4D, ValidD, CtrlE, RD1E, RD2E,
           RsE, RtE, RdE, SignImmE, ValidE, StallCnt, FlushCnt
  );

  modport slave (
    input  PCNextF, InstrF, StallF, StallD, FlushD, FlushE,
           CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    output PCF, InstrD, PCPlus4D, ValidD, CtrlE, RD1E, RD2E,
           RsE, RtE, RdE, SignImmE, ValidE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC register, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core.
// Valid tags mark real instructions versus bubbles through D and E.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise StallCnt/FlushCnt are tied to zero.
module pipe_stage_regs #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        REG_W    = 5,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_regs_if.slave   bus
);

  localparam int unsigned CNT_W = 32;

  logic [DATA_W-1:0] pcf_q, pcf_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [DATA_W-1:0] id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
  logic [REG_W-1:0]  ex_rs_q, ex_rs_d;
  logic [REG_W-1:0]  ex_rt_q, ex_rt_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic              ex_valid_q, ex_valid_d;

  // Next-state for PC, IF/ID and ID/EX; stall beats flush in D, E is never held.
  always_comb begin
    pcf_d      = pcf_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    if (!bus.StallF) begin
      pcf_d = bus.PCNextF;
    end

    if (!bus.StallD) begin
      if (bus.FlushD) begin
        id_instr_d = '0;
        id_pc4_d   = '0;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = bus.InstrF;
        id_pc4_d   = pcf_q + DATA_W'(4);
        id_valid_d = 1'b1;
      end
    end

    if (bus.FlushE) begin
      ex_ctrl_d  = '0;
      ex_rd1_d   = '0;
      ex_rd2_d   = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      ex_imm_d   = '0;
      ex_valid_d = 1'b0;
    end else begin
      ex_ctrl_d  = bus.CtrlD;
      ex_rd1_d   = bus.RD1D;
      ex_rd2_d   = bus.RD2D;
      ex_rs_d    = bus.RsD;
      ex_rt_d    = bus.RtD;
      ex_rd_d    = bus.RdD;
      ex_imm_d   = bus.SignImmD;
      ex_valid_d = id_valid_q;
    end
  end

  // Pipeline state registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q      <= RESET_PC;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_imm_q   <= ex_imm_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating stall/flush event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((bus.FlushE || (bus.FlushD && !bus.StallD)) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;
`else
  assign bus.StallCnt = CNT_W'(0);
  assign bus.FlushCnt = CNT_W'(0);
`endif

  assign bus.PCF      = pcf_q;
  assign bus.InstrD   = id_instr_q;
  assign bus.PCPlus4D = id_pc4_q;
  assign bus.ValidD   = id_valid_q;
  assign bus.CtrlE    = ex_ctrl_q;
  assign bus.RD1E     = ex_rd1_q;
  assign bus.RD2E     = ex_rd2_q;
  assign bus.RsE      = ex_rs_q;
  assign bus.RtE      = ex_rt_q;
  assign bus.RdE      = ex_rd_q;
  assign bus.SignImmE = ex_imm_q;
  assign bus.ValidE   = ex_valid_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: random and directed hazard-control stimulus,
// expected pipeline contents predicted by an instruction-slot model and
// checked by a monitor draining a scoreboard queue.
module tb_pipe_stage_regs;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_stage_regs_if #(.DATA_W(32), .REG_W(5), .CTRL_W(8)) bus ();

  pipe_stage_regs #(
    .DATA_W(32), .REG_W(5), .CTRL_W(8), .RESET_PC(RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] pcnext;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        stallf;
    logic        stalld;
    logic        flushd;
    logic        flushe;
  } stim_t;

  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] instrd;
    logic [31:0] pc4d;
    logic        validd;
    logic [7:0]  ctrle;
    logic [31:0] rd1e;
    logic [31:0] rd2e;
    logic [4:0]  rse;
    logic [4:0]  rte;
    logic [4:0]  rde;
    logic [31:0] imme;
    logic        valide;
    logic [31:0] stallcnt;
    logic [31:0] flushcnt;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t scb[$];

  // Architectural view: fetch PC, decode slot, execute slot, event totals.
  exp_t            m;
  longint unsigned m_stalls;
  longint unsigned m_flushes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat32(input longint unsigned v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    m         = '0;
    m.pcf     = RST_PC;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Advance the slot model by one clock edge.
  task automatic model_step(input stim_t s, output exp_t e);
    exp_t n;
    n = m;
    if (s.flushe) begin
      n.ctrle = '0; n.rd1e = '0; n.rd2e = '0; n.imme = '0;
      n.rse = '0; n.rte = '0; n.rde = '0; n.valide = 1'b0;
    end else begin
      n.ctrle = s.ctrl; n.rd1e = s.rd1; n.rd2e = s.rd2; n.imme = s.imm;
      n.rse = s.rs; n.rte = s.rt; n.rde = s.rd; n.valide = m.validd;
    end
    if (!s.stalld) begin
      if (s.flushd) begin
        n.instrd = '0; n.pc4d = '0; n.validd = 1'b0;
      end else begin
        n.instrd = s.instr; n.pc4d = m.pcf + 32'd4; n.validd = 1'b1;
      end
    end
    if (!s.stallf) n.pcf = s.pcnext;
    if (s.stalld) m_stalls++;
    if (s.flushe || (s.flushd && !s.stalld)) m_flushes++;
`ifdef HAZARD_STATS_EN
    n.stallcnt = sat32(m_stalls);
    n.flushcnt = sat32(m_flushes);
`else
    n.stallcnt = '0;
    n.flushcnt = '0;
`endif
    m = n;
    e = n;
  endtask

  task automatic apply(input stim_t s);
    bus.PCNextF  = s.pcnext;
    bus.InstrF   = s.instr;
    bus.RD1D     = s.rd1;
    bus.RD2D     = s.rd2;
    bus.SignImmD = s.imm;
    bus.CtrlD    = s.ctrl;
    bus.RsD      = s.rs;
    bus.RtD      = s.rt;
    bus.RdD      = s.rd;
    bus.StallF   = s.stallf;
    bus.StallD   = s.stalld;
    bus.FlushD   = s.flushd;
    bus.FlushE   = s.flushe;
  endtask

  function automatic stim_t base_stim();
    stim_t s;
    s        = '0;
    s.pcnext = m.pcf + 32'd4;
    s.instr  = $urandom;
    s.rd1    = $urandom;
    s.rd2    = $urandom;
    s.imm    = $urandom;
    s.ctrl   = 8'($urandom);
    s.rs     = 5'($urandom);
    s.rt     = 5'($urandom);
    s.rd     = 5'($urandom);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = base_stim();
    if ($urandom_range(0, 3) == 0) s.pcnext = $urandom;
    s.stalld = ($urandom_range(0, 3) == 0);
    s.stallf = ($urandom_range(0, 7) == 0) ? !s.stalld : s.stalld;
    s.flushd = ($urandom_range(0, 4) == 0);
    s.flushe = ($urandom_range(0, 4) == 0);
    return s;
  endfunction

  // Called on a falling edge: drive, predict, wait for the next falling edge.
  task automatic step(input stim_t s);
    exp_t e;
    apply(s);
    model_step(s, e);
    scb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() != 0) begin
        e = scb.pop_front();
        chk("PCF",      bus.PCF,             e.pcf);
        chk("InstrD",   bus.InstrD,          e.instrd);
        chk("PCPlus4D", bus.PCPlus4D,        e.pc4d);
        chk("ValidD",   32'(bus.ValidD),     32'(e.validd));
        chk("CtrlE",    32'(bus.CtrlE),      32'(e.ctrle));
        chk("RD1E",     bus.RD1E,            e.rd1e);
        chk("RD2E",     bus.RD2E,            e.rd2e);
        chk("RsE",      32'(bus.RsE),        32'(e.rse));
        chk("RtE",      32'(bus.RtE),        32'(e.rte));
        chk("RdE",      32'(bus.RdE),        32'(e.rde));
        chk("SignImmE", bus.SignImmE,        e.imme);
        chk("ValidE",   32'(bus.ValidE),     32'(e.valide));
        chk("StallCnt", bus.StallCnt,        e.stallcnt);
        chk("FlushCnt", bus.FlushCnt,        e.flushcnt);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    model_reset();
    apply(base_stim());
    #12;
    chk("rst_PCF",    bus.PCF,           RST_PC);
    chk("rst_InstrD", bus.InstrD,        32'h0);
    chk("rst_ValidD", 32'(bus.ValidD),   32'h0);
    chk("rst_ValidE", 32'(bus.ValidE),   32'h0);
    chk("rst_CtrlE",  32'(bus.CtrlE),    32'h0);
    chk("rst_Stall",  bus.StallCnt,      32'h0);

    // Sequential fetch after reset release
    @(negedge clk);
    reset = 1'b0;
    step(base_stim());
    chk("t1_PCF0",    bus.PCF,         32'h0040_0004);
    chk("t1_ValidD0", 32'(bus.ValidD), 32'h1);
    chk("t1_ValidE0", 32'(bus.ValidE), 32'h0);
    step(base_stim());
    chk("t1_PCF1",    bus.PCF,         32'h0040_0008);
    chk("t1_ValidE1", 32'(bus.ValidE), 32'h1);

    // Load-use stall: lw held in D while E takes a bubble
    s = base_stim(); s.instr = 32'h8C08_0004;
    step(s);
    s = base_stim(); s.stallf = 1'b1; s.stalld = 1'b1; s.flushe = 1'b1;
    step(s);
    chk("t2_PCF_hold",  bus.PCF,         32'h0040_000C);
    chk("t2_InstrD",    bus.InstrD,      32'h8C08_0004);
    chk("t2_ValidE",    32'(bus.ValidE), 32'h0);
    chk("t2_CtrlE",     32'(bus.CtrlE),  32'h0);
    s = base_stim(); s.ctrl = 8'hA5;
    step(s);
    chk("t2_lw_ValidE", 32'(bus.ValidE), 32'h1);
    chk("t2_lw_CtrlE",  32'(bus.CtrlE),  32'h0000_00A5);

    // Branch flush of D
    s = base_stim(); s.flushd = 1'b1; s.instr = 32'h2009_0001;
    step(s);
    chk("t3_InstrD",   bus.InstrD,      32'h0);
    chk("t3_PCPlus4D", bus.PCPlus4D,    32'h0);
    chk("t3_ValidD",   32'(bus.ValidD), 32'h0);
    step(base_stim());
    chk("t3_ValidE",   32'(bus.ValidE), 32'h0);

    // Stall has priority over FlushD
    s = base_stim(); s.instr = 32'h0128_5020;
    step(s);
    s = base_stim(); s.flushd = 1'b1; s.stalld = 1'b1; s.stallf = 1'b1;
    step(s);
    chk("t4_InstrD", bus.InstrD,      32'h0128_5020);
    chk("t4_ValidD", 32'(bus.ValidD), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) step(rand_stim());

    // Asynchronous reset between edges during a stall
    s = base_stim(); s.stallf = 1'b1; s.stalld = 1'b1;
    apply(s);
    #2 reset = 1'b1;
    #1;
    chk("t5_PCF",    bus.PCF,         RST_PC);
    chk("t5_ValidD", 32'(bus.ValidD), 32'h0);
    chk("t5_ValidE", 32'(bus.ValidE), 32'h0);
    chk("t5_InstrD", bus.InstrD,      32'h0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Counters: three stall cycles then two E flushes
    for (int i = 0; i < 3; i++) begin
      s = base_stim(); s.stallf = 1'b1; s.stalld = 1'b1;
      step(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = base_stim(); s.flushe = 1'b1;
      step(s);
    end
`ifdef HAZARD_STATS_EN
    chk("t6_StallCnt", bus.StallCnt, 32'd3);
    chk("t6_FlushCnt", bus.FlushCnt, 32'd2);
`else
    chk("t6_StallCnt", bus.StallCnt, 32'd0);
    chk("t6_FlushCnt", bus.FlushCnt, 32'd0);
`endif

    @(negedge clk);
    chk("scb_drained", 32'(scb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
